// File: rtl/motion_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// motion_alarm_ctrl
//   Multi-zone motion alarm controller. Each PIR input is synchronised and
//   debounced. An arm/disarm FSM with an exit delay, per-zone latching, an
//   alarm hold timeout and a continuous or beeping buzzer turns the debounced
//   zones into a buzzer drive.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   motion_in     [N_CH] raw asynchronous sensor outputs
//   ch_enable     [N_CH] per-zone enable (disabled zones never trigger/latch)
//   arm           level: 1 = arm requested, 0 = disarm
//   clear         one-cycle pulse clearing zone_latched (ignored in ALARM)
//   beep_mode     0 = continuous buzzer, 1 = beeping buzzer
//   buzzer        buzzer drive
//   alarm_active  high while state = ALARM
//   motion_valid  [N_CH] debounced motion, not masked by ch_enable
//   zone_latched  [N_CH] zones that triggered since the last clear
//   state         00 DISARMED, 01 ARMING, 10 ARMED, 11 ALARM
// ----------------------------------------------------------------------------
module motion_alarm_ctrl #(
    parameter int N_CH          = 4,
    parameter int DEBOUNCE_CYC  = 2500,
    parameter int ARM_DELAY_CYC = 50000000,
    parameter int HOLD_CYC      = 50000000,
    parameter int BEEP_HALF_CYC = 6250000,
    parameter int CNT_W         = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] motion_in,
    input  logic [N_CH-1:0] ch_enable,
    input  logic            arm,
    input  logic            clear,
    input  logic            beep_mode,
    output logic            buzzer,
    output logic            alarm_active,
    output logic [N_CH-1:0] motion_valid,
    output logic [N_CH-1:0] zone_latched,
    output logic [1:0]      state
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(ARM_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  BEEP_LAST = CNT_W'(BEEP_HALF_CYC - 1);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMING   = 2'b01,
        ST_ARMED    = 2'b10,
        ST_ALARM    = 2'b11
    } state_t;

    state_t           state_q;
    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [DB_W-1:0]  db_cnt [N_CH];
    logic [N_CH-1:0]  trig;
    logic             any_trig;
    logic [CNT_W-1:0] arm_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] beep_cnt;
    logic             beep_phase;
    logic             beep_wrap;
    logic             beep_phase_next;

    assign state = state_q;

    // Two-flop synchroniser per channel.
    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= motion_in;
            sync2 <= sync1;
        end
    end

    // Debounce: count while the synchronised input is high (saturating);
    // valid once the count has reached DEBOUNCE_CYC with the input still high.
    // Any low sample clears both the count and the valid flag.
    // NOTE: the counter array is small and must come up at 0, so it sits on the
    // reset like any other flop (it is not a RAM).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
            motion_valid <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i]) begin
                    if (db_cnt[i] != DB_MAX) begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                    motion_valid[i] <= (db_cnt[i] == DB_MAX);
                end else begin
                    db_cnt[i]       <= '0;
                    motion_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign trig     = motion_valid & ch_enable;
    assign any_trig = |trig;

    // Beep phase advances every BEEP_HALF_CYC cycles spent in ALARM and is not
    // disturbed by re-triggers.
    assign beep_wrap       = (beep_cnt == BEEP_LAST);
    assign beep_phase_next = beep_wrap ? ~beep_phase : beep_phase;

    // Arm/alarm FSM. buzzer and alarm_active are loaded from the state being
    // entered, so they change on the same edge as state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_DISARMED;
            arm_cnt      <= '0;
            hold_cnt     <= '0;
            beep_cnt     <= '0;
            beep_phase   <= 1'b0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            zone_latched <= '0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (clear) zone_latched <= '0;
                    if (arm) begin
                        state_q <= ST_ARMING;
                        arm_cnt <= '0;
                    end
                end

                ST_ARMING: begin
                    // Motion is ignored during the exit delay.
                    if (clear) zone_latched <= '0;
                    if (!arm) begin
                        state_q <= ST_DISARMED;
                    end else if (arm_cnt == ARM_LAST) begin
                        state_q <= ST_ARMED;
                    end else begin
                        arm_cnt <= arm_cnt + CNT_W'(1);
                    end
                end

                ST_ARMED: begin
                    if (!arm) begin
                        state_q <= ST_DISARMED;
                        if (clear) zone_latched <= '0;
                    end else if (any_trig) begin
                        state_q      <= ST_ALARM;
                        // A simultaneous clear drops old zones but keeps the new one.
                        zone_latched <= clear ? trig : (zone_latched | trig);
                        hold_cnt     <= '0;
                        beep_cnt     <= '0;
                        beep_phase   <= 1'b1;
                        buzzer       <= 1'b1;
                        alarm_active <= 1'b1;
                    end else if (clear) begin
                        zone_latched <= '0;
                    end
                end

                ST_ALARM: begin
                    // clear is deliberately not honoured here.
                    beep_cnt   <= beep_wrap ? '0 : beep_cnt + CNT_W'(1);
                    beep_phase <= beep_phase_next;
                    buzzer     <= beep_mode ? beep_phase_next : 1'b1;
                    // NOTE: the exit branches below assign buzzer again; the last
                    // non-blocking assignment in the block is the one that lands.
                    if (!arm) begin
                        state_q      <= ST_DISARMED;
                        buzzer       <= 1'b0;
                        alarm_active <= 1'b0;
                    end else if (any_trig) begin
                        zone_latched <= zone_latched | trig;
                        hold_cnt     <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_q      <= ST_ARMED;
                        buzzer       <= 1'b0;
                        alarm_active <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state_q      <= ST_DISARMED;
                    buzzer       <= 1'b0;
                    alarm_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_motion_alarm_ctrl
//   Directed bench for motion_alarm_ctrl. The stimulus process pushes expected
//   output values, tagged with the clock-edge count after which they must hold,
//   into a scoreboard queue; a monitor on the falling edge pops and compares
//   every entry that falls due.
// ----------------------------------------------------------------------------
module tb_motion_alarm_ctrl;

    localparam int N_CH = 4;

    localparam int S_STATE = 0;
    localparam int S_BUZZ  = 1;
    localparam int S_ALARM = 2;
    localparam int S_MV    = 3;
    localparam int S_ZL    = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] motion_in = '0;
    logic [N_CH-1:0] ch_enable = '0;
    logic            arm = 1'b0;
    logic            clear = 1'b0;
    logic            beep_mode = 1'b0;
    logic            buzzer;
    logic            alarm_active;
    logic [N_CH-1:0] motion_valid;
    logic [N_CH-1:0] zone_latched;
    logic [1:0]      state;

    motion_alarm_ctrl #(
        .N_CH         (N_CH),
        .DEBOUNCE_CYC (4),
        .ARM_DELAY_CYC(10),
        .HOLD_CYC     (20),
        .BEEP_HALF_CYC(3),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .motion_in   (motion_in),
        .ch_enable   (ch_enable),
        .arm         (arm),
        .clear       (clear),
        .beep_mode   (beep_mode),
        .buzzer      (buzzer),
        .alarm_active(alarm_active),
        .motion_valid(motion_valid),
        .zone_latched(zone_latched),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit flush    = 1'b0;

    int         exp_cyc  [$];
    int         exp_sel  [$];
    logic [7:0] exp_val  [$];
    string      exp_name [$];

    function automatic logic [7:0] actual(int sel);
        case (sel)
            S_STATE: return 8'(state);
            S_BUZZ:  return 8'(buzzer);
            S_ALARM: return 8'(alarm_active);
            S_MV:    return 8'(motion_valid);
            default: return 8'(zone_latched);
        endcase
    endfunction

    task automatic push(string name, int sel, int at, logic [7:0] val);
        exp_cyc.push_back(at);
        exp_sel.push_back(sel);
        exp_val.push_back(val);
        exp_name.push_back($sformatf("%s@%0d", name, at));
    endtask

    task automatic push_reset_state(string name, int at);
        push({name, "_state"}, S_STATE, at, 8'd0);
        push({name, "_buzzer"}, S_BUZZ, at, 8'd0);
        push({name, "_alarm"}, S_ALARM, at, 8'd0);
        push({name, "_mv"}, S_MV, at, 8'd0);
        push({name, "_zl"}, S_ZL, at, 8'd0);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare due entries; anything overdue or left at the end fails.
    always @(negedge clk) begin
        for (int i = exp_cyc.size() - 1; i >= 0; i--) begin
            if (flush || exp_cyc[i] < cyc) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL %s: never sampled, expected %0h", exp_name[i], exp_val[i]);
                exp_cyc.delete(i); exp_sel.delete(i); exp_val.delete(i); exp_name.delete(i);
            end else if (exp_cyc[i] == cyc) begin
                checks = checks + 1;
                if (actual(exp_sel[i]) !== exp_val[i]) begin
                    failures = failures + 1;
                    $display("FAIL %s: got %0h expected %0h",
                             exp_name[i], actual(exp_sel[i]), exp_val[i]);
                end
                exp_cyc.delete(i); exp_sel.delete(i); exp_val.delete(i); exp_name.delete(i);
            end
        end
    end

    initial begin
        int base;

        // Reset state
        tick(2);
        push_reset_state("rst", cyc);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Glitch of 3 cycles never becomes valid
        base = cyc;
        motion_in = 4'b0001;
        push("glitch_mv", S_MV, base + 5, 8'h0);
        push("glitch_mv", S_MV, base + 7, 8'h0);
        push("glitch_mv", S_MV, base + 9, 8'h0);
        tick(3);
        motion_in = 4'b0000;
        tick(10);

        // Held high: valid after edge 6 from first sampling edge; falls 2 after release
        base = cyc;
        motion_in = 4'b0001;
        push("deb_mv_lo", S_MV, base + 6, 8'h0);
        push("deb_mv_hi", S_MV, base + 7, 8'h1);
        push("disarm_zl", S_ZL, base + 7, 8'h0);
        push("disarm_state", S_STATE, base + 7, 8'h0);
        tick(10);
        motion_in = 4'b0000;
        push("rel_mv_hi", S_MV, cyc + 2, 8'h1);
        push("rel_mv_lo", S_MV, cyc + 3, 8'h0);
        tick(5);

        // Arm, then abort in the 5th ARMING cycle
        base = cyc;
        arm = 1'b1;
        push("abort_arming", S_STATE, base + 1, 8'h1);
        push("abort_arming5", S_STATE, base + 5, 8'h1);
        push("abort_disarm", S_STATE, base + 6, 8'h0);
        push("abort_alarm", S_ALARM, base + 6, 8'h0);
        tick(5);
        arm = 1'b0;
        tick(3);

        // Full arm sequence with motion during ARMING (ignored)
        base = cyc;
        arm = 1'b1;
        ch_enable = 4'b1111;
        motion_in = 4'b0010;
        push("arm_arming", S_STATE, base + 1, 8'h1);
        push("arm_mv", S_MV, base + 7, 8'h2);
        push("arm_last", S_STATE, base + 10, 8'h1);
        push("arm_armed", S_STATE, base + 11, 8'h2);
        push("arm_nolatch", S_ZL, base + 11, 8'h0);
        push("arm_buzz", S_BUZZ, base + 11, 8'h0);
        tick(6);
        motion_in = 4'b0000;
        tick(6);

        // Trigger with enable mask: ch1 masked, ch2 triggers; later ch0
        ch_enable = 4'b0101;
        beep_mode = 1'b0;
        base = cyc;
        motion_in = 4'b0110;
        push("trig_pre_state", S_STATE, base + 7, 8'h2);
        push("trig_pre_buzz", S_BUZZ, base + 7, 8'h0);
        push("trig_state", S_STATE, base + 8, 8'h3);
        push("trig_zl", S_ZL, base + 8, 8'h4);
        push("trig_alarm", S_ALARM, base + 8, 8'h1);
        for (int k = 8; k <= 12; k++) push("cont_buzz", S_BUZZ, base + k, 8'h1);
        push("ch0_zl_pre", S_ZL, base + 17, 8'h4);
        push("ch0_zl", S_ZL, base + 18, 8'h5);
        push("clr_alarm_zl", S_ZL, base + 20, 8'h5);
        push("clr_alarm_state", S_STATE, base + 20, 8'h3);
        tick(10);
        motion_in = 4'b0111;
        tick(9);
        clear = 1'b1;             // in ALARM: ignored
        tick(1);
        clear = 1'b0;
        tick(1);

        // Disarm on the same edge as a new zone trigger: disarm wins, latches kept
        arm = 1'b0;
        ch_enable = 4'b0111;
        push("prio_state", S_STATE, cyc + 1, 8'h0);
        push("prio_buzz", S_BUZZ, cyc + 1, 8'h0);
        push("prio_alarm", S_ALARM, cyc + 1, 8'h0);
        push("prio_zl", S_ZL, cyc + 1, 8'h5);
        push("prio_zl_kept", S_ZL, cyc + 2, 8'h5);
        push("clr_disarm_zl", S_ZL, cyc + 3, 8'h0);
        tick(2);
        clear = 1'b1;
        motion_in = 4'b0000;
        tick(1);
        clear = 1'b0;
        tick(4);

        // Beep pattern and hold timeout after the last valid trigger
        arm = 1'b1;
        ch_enable = 4'b0101;
        beep_mode = 1'b1;
        tick(12);
        base = cyc;
        motion_in = 4'b0001;
        push("hold_pre", S_STATE, base + 7, 8'h2);
        push("hold_enter", S_STATE, base + 8, 8'h3);
        push("hold_zl", S_ZL, base + 8, 8'h1);
        for (int k = 0; k <= 20; k++)
            push("beep", S_BUZZ, base + 8 + k, (((k / 3) % 2) == 0) ? 8'h1 : 8'h0);
        push("hold_last", S_STATE, base + 28, 8'h3);
        push("hold_exit", S_STATE, base + 29, 8'h2);
        push("hold_exit_buzz", S_BUZZ, base + 29, 8'h0);
        push("hold_exit_alarm", S_ALARM, base + 29, 8'h0);
        tick(6);
        motion_in = 4'b0000;
        tick(24);

        // Re-trigger 15 cycles into the hold restarts it; beep_mode change
        base = cyc;
        motion_in = 4'b0100;
        push("rt_enter", S_STATE, base + 8, 8'h3);
        push("rt_no_early_exit", S_STATE, base + 29, 8'h3);
        push("rt_last", S_STATE, base + 44, 8'h3);
        push("rt_exit", S_STATE, base + 45, 8'h2);
        push("mode_beep_lo", S_BUZZ, base + 30, 8'h0);
        push("mode_cont", S_BUZZ, base + 31, 8'h1);
        push("mode_cont2", S_BUZZ, base + 32, 8'h1);
        tick(6);
        motion_in = 4'b0000;
        tick(10);
        motion_in = 4'b0100;
        tick(6);
        motion_in = 4'b0000;
        tick(8);
        beep_mode = 1'b0;
        tick(3);
        beep_mode = 1'b1;
        tick(13);

        // Reset mid-ALARM with buzzer high, then clean restart
        base = cyc;
        motion_in = 4'b0001;
        push("pre_rst_state", S_STATE, base + 8, 8'h3);
        push("pre_rst_buzz", S_BUZZ, base + 8, 8'h1);
        tick(9);
        reset = 1'b1;
        push_reset_state("async_rst", cyc);
        tick(2);
        reset = 1'b0;
        base = cyc;
        push("restart_arming", S_STATE, base + 1, 8'h1);
        push("restart_mv_lo", S_MV, base + 6, 8'h0);
        push("restart_mv_hi", S_MV, base + 7, 8'h1);
        push("restart_armed", S_STATE, base + 11, 8'h2);
        push("restart_alarm", S_STATE, base + 12, 8'h3);
        push("restart_buzz", S_BUZZ, base + 12, 8'h1);
        tick(14);

        flush = 1'b1;
        tick(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_alarm_ctrl.md
Name: motion_alarm_ctrl

Overview:
Multi-zone motion alarm controller and parametrised successor of the single-sensor debounce/buzzer block. Each of N_CH PIR inputs is synchronised and debounced. An arm/disarm state machine with exit delay, per-zone latching, alarm hold timeout and a continuous or beeping buzzer drive turns the debounced zones into a buzzer output. The block sits between the raw sensor pins and the buzzer pin, with zone status exported for LEDs/display.

Parameters:
N_CH, 4, number of sensor channels (>=1)
DEBOUNCE_CYC, 2500, cycles a synchronised input must stay high before it is valid (>=1)
ARM_DELAY_CYC, 50000000, exit delay from arm request to ARMED (>=1)
HOLD_CYC, 50000000, alarm hold time after the last valid enabled motion (>=1)
BEEP_HALF_CYC, 6250000, buzzer half-period in beep mode (>=1)
CNT_W, 26, width of the arm/hold/beep counters; must hold max(ARM_DELAY_CYC, HOLD_CYC, BEEP_HALF_CYC)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
motion_in  input  N_CH  raw, asynchronous sensor outputs
ch_enable  input  N_CH  per-zone enable; disabled zones cannot trigger or latch
arm  input  1  level: 1 = armed requested, 0 = disarm
clear  input  1  one-cycle pulse: clears zone_latched
beep_mode  input  1  0 = continuous buzzer, 1 = beeping buzzer
buzzer  output  1  buzzer drive
alarm_active  output  1  high while state = ALARM
motion_valid  output  N_CH  debounced motion per channel, unmasked
zone_latched  output  N_CH  zones that triggered since the last clear
state  output  2  00 DISARMED, 01 ARMING, 10 ARMED, 11 ALARM

Behaviour:
- Reset is asynchronous and active-high. Clock is clk. On reset, all outputs, counters and sync flops go to 0 and state goes to DISARMED. This also applies mid-alarm.
- Synchroniser: two flops per channel.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYC+1):
  - While sync output = 1, the counter increments and saturates at DEBOUNCE_CYC.
  - motion_valid is registered high when sync = 1 and counter == DEBOUNCE_CYC.
  - When sync = 0, the counter and motion_valid clear on the next edge.
- Latency: motion_in is first sampled high at edge 0; motion_valid is high after edge DEBOUNCE_CYC+2. motion_in is first sampled low at edge m; motion_valid is low after edge m+2. A glitch shorter than the debounce window never sets motion_valid.
- trig = motion_valid & ch_enable. any = |trig.
- DISARMED: arm = 1 -> ARMING, arm counter = 0.
- ARMING:
  - arm = 0 -> DISARMED.
  - Otherwise the counter increments; when it reaches ARM_DELAY_CYC-1 -> ARMED.
  - Motion is ignored.
- ARMED:
  - arm = 0 -> DISARMED.
  - any -> ALARM; zone_latched |= trig; hold counter = 0; beep counter = 0.
  - This is level-sensitive: motion already valid when ARMED is entered triggers on the next edge.
- ALARM:
  - arm = 0 -> DISARMED, which has priority over simultaneous motion.
  - any -> zone_latched |= trig and the hold counter restarts at 0.
  - Otherwise the hold counter increments; when it reaches HOLD_CYC-1 with no trigger -> ARMED.
- zone_latched:
  - Cleared by clear in any state except ALARM; clear is ignored in ALARM.
  - Survives the ALARM->ARMED and ->DISARMED transitions.
  - clear and a new trigger in ARMED on the same edge: the result is trig, so the new zone wins.
- ch_enable dropped during ALARM: the alarm continues on the hold timer, and that zone adds no new latches or hold restarts.
- buzzer and alarm_active are registered from the next state, so they go high on the same edge that state becomes ALARM and go low on the edge it leaves.
  - beep_mode = 0: buzzer = 1 throughout ALARM.
  - beep_mode = 1: buzzer = 1 for BEEP_HALF_CYC cycles, then 0 for BEEP_HALF_CYC, and so on, starting at 1 on ALARM entry. The beep phase is not restarted by re-triggers. A beep_mode change takes effect on the next edge.
  - buzzer = 0 in every other state.
- Counters never wrap; the arm and hold counters reset on every state entry.

Test Plan:
(Test parameters: N_CH=4, DEBOUNCE_CYC=4, ARM_DELAY_CYC=10, HOLD_CYC=20, BEEP_HALF_CYC=3.)
Debounce: motion_in[0] high 3 cycles then low -> motion_valid stays 0. Held high -> motion_valid[0] rises after edge 6 from the first sampling edge; falls 2 edges after release.
Arm sequence: arm=1 -> state 01 for 10 cycles, then 10. arm=0 at cycle 5 of ARMING -> 00 with no alarm. Motion during ARMING -> no latch.
Trigger/latch: ARMED, ch_enable=4'b0101, motion on ch1 and ch2 -> ALARM from ch2 only, zone_latched=4'b0100, buzzer=1 continuous with beep_mode=0. Later ch0 -> zone_latched=4'b0101.
Hold/beep: beep_mode=1, single trigger then quiet -> buzzer 1,1,1,0,0,0,... and return to ARMED exactly 20 cycles after the last valid trigger. Re-trigger at cycle 15 -> hold restarts.
Priority/clear: arm falls in the same cycle as a new trigger -> DISARMED, buzzer=0, latches kept. clear in ALARM -> ignored. clear in DISARMED -> zone_latched=0.
Reset mid-ALARM with beep high -> all outputs 0 immediately (asynchronous), state 00. Clean restart after deassertion.
